gt_pll_reset_ctrl: RTL
======================

GT_PLL_RESET_CTRL -- requirements
Module: gt_pll_reset_ctrl

Interface
REQ-001 SHALL have parameter T_PWRUP, default 16'd400, PLL held in reset after power-down release (CLK cycles).
REQ-002 SHALL have parameter T_LOCK, default 16'd50000, lock-wait timeout (CLK cycles).
REQ-003 SHALL have parameter T_SETTLE, default 16'd256, consecutive synced-lock cycles required before ready.
REQ-004 SHALL have parameter MAX_RETRY, default 4'd3, lock timeouts tolerated before FAULT.
REQ-005 SHALL have CLK  input  1  free-running controller clock, also drives PLLxLOCKDETCLK externally.
REQ-006 SHALL have RST_N  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have EN0 / EN1  input  1 each  request PLL0 / PLL1 operational.
REQ-008 SHALL have RETRY0 / RETRY1  input  1 each  single-cycle pulse, clears FAULT of that PLL.
REQ-009 SHALL have PLL0LOCK / PLL1LOCK  input  1 each  asynchronous lock from the GT common block.
REQ-010 SHALL have PLL0REFCLKLOST / PLL1REFCLKLOST  input  1 each  asynchronous refclk-lost flag.
REQ-011 SHALL have PLL0PD / PLL1PD  output  1 each  power-down drive to GT common.
REQ-012 SHALL have PLL0RESET / PLL1RESET  output  1 each  reset drive to GT common.
REQ-013 SHALL have PLL0READY / PLL1READY  output  1 each  PLL locked and settled.
REQ-014 SHALL have PLL0FAULT / PLL1FAULT  output  1 each  retries exhausted.
REQ-015 SHALL have STATE0 / STATE1  output  3 each  current FSM state encoding (debug).
REQ-016 SHALL have RELOCK_CNT0 / RELOCK_CNT1  output  8 each  saturating count of lock losses from READY.

Function
REQ-017 SHALL run two independent identical channels (PLL0, PLL1); no shared state between them.
REQ-018 SHALL synchronise LOCK and REFCLKLOST through 2 CLK flops each; FSM uses synced values only.
REQ-019 SHALL implement states IDLE=0, PWRUP=1, WAIT_LOCK=2, SETTLE=3, READY=4, REFWAIT=5, FAULT=6.
REQ-020 SHALL drive per state (PD,RESET,READY,FAULT): IDLE 1,1,0,0; PWRUP 0,1,0,0; WAIT_LOCK/SETTLE 0,0,0,0; READY 0,0,1,0; REFWAIT 0,1,0,0; FAULT 1,1,0,1; all outputs registered.
REQ-021 SHALL go IDLE->PWRUP when EN=1; PWRUP lasts exactly T_PWRUP cycles then ->WAIT_LOCK.
REQ-022 SHALL in WAIT_LOCK go ->SETTLE on synced lock=1; on T_LOCK cycles without lock increment retry count and go ->PWRUP if count<MAX_RETRY, else ->FAULT.
REQ-023 SHALL in SETTLE go ->READY after T_SETTLE consecutive lock=1 cycles; lock=0 returns to WAIT_LOCK with timeout counter restarted.
REQ-024 SHALL in READY on lock=0 increment RELOCK_CNT (saturate at 255), clear retry count, go ->PWRUP.
REQ-025 SHALL in PWRUP/WAIT_LOCK/SETTLE/READY on synced REFCLKLOST=1 go ->REFWAIT; leave to PWRUP on first cycle REFCLKLOST=0; retry count unchanged.
REQ-026 SHALL in FAULT stay until RETRY=1 (->PWRUP, retry count cleared) or EN=0 (->IDLE).
REQ-027 SHALL give priority EN=0 > REFCLKLOST > lock/timeout when simultaneous; EN=0 forces IDLE next cycle from any state.
REQ-028 SHALL clear retry count on entry to IDLE and READY; RELOCK_CNT cleared only by reset.
REQ-029 SHALL use one 16-bit cycle counter per channel, cleared on every state change.

Reset
REQ-030 SHALL on RST_N=0 immediately force state IDLE, PD=1, RESET=1, READY=0, FAULT=0, counters 0, sync flops 0.
REQ-031 SHALL release reset synchronously internally (2-flop reset synchroniser on RST_N deassertion).
REQ-032 SHALL treat reset mid-sequence identically to power-on; no state retained.

Structure
REQ-033 SHALL place state enum, state encodings and counter width constant in shared package gt_pll_ctrl_pkg.
REQ-034 SHALL implement one channel as sub-module gt_pll_rst_fsm, instantiated twice.

Verification (T_PWRUP=4, T_LOCK=20, T_SETTLE=3, MAX_RETRY=2)
REQ-035 SHALL test nominal: EN0=1, LOCK0 high 10 cycles after WAIT_LOCK entry -> PD0=0 at cycle 1, RESET0 low after 4 PWRUP cycles, READY0=1 after 2 sync + 3 settle cycles.
REQ-036 SHALL test timeout: LOCK0 stuck 0 -> two PWRUP/WAIT_LOCK rounds, then FAULT0=1, PD0=1; RETRY0 pulse -> PWRUP.
REQ-037 SHALL test lock loss: in READY drop LOCK0 -> READY0=0 within 3 cycles, RELOCK_CNT0=1, re-lock -> READY0=1; 256 losses -> RELOCK_CNT0=255.
REQ-038 SHALL test refclk lost: REFCLKLOST1=1 in WAIT_LOCK -> STATE1=5, RESET1=1; clear -> PWRUP, retry count unchanged.
REQ-039 SHALL test priority/reset: EN0=0 with REFCLKLOST0=1 same cycle -> IDLE; RST_N=0 in READY -> all outputs at reset values asynchronously; channel 1 unaffected by channel 0 activity.

Source files
------------

// File: rtl/gt_pll_ctrl_pkg.sv
// Shared types and constants for the GT common PLL reset controller.
package gt_pll_ctrl_pkg;

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PWRUP     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_READY     = 3'd4,
    ST_REFWAIT   = 3'd5,
    ST_FAULT     = 3'd6
  } pll_state_e;

  typedef struct packed {
    logic pd;
    logic rst;
    logic rdy;
    logic flt;
  } pll_drv_t;

  // Output drive pattern associated with each state.
  function automatic pll_drv_t state_drive(input pll_state_e s);
    pll_drv_t d;
    d = '{pd: 1'b1, rst: 1'b1, rdy: 1'b0, flt: 1'b0};
    case (s)
      ST_IDLE:                  d = '{pd: 1'b1, rst: 1'b1, rdy: 1'b0, flt: 1'b0};
      ST_PWRUP, ST_REFWAIT:     d = '{pd: 1'b0, rst: 1'b1, rdy: 1'b0, flt: 1'b0};
      ST_WAIT_LOCK, ST_SETTLE:  d = '{pd: 1'b0, rst: 1'b0, rdy: 1'b0, flt: 1'b0};
      ST_READY:                 d = '{pd: 1'b0, rst: 1'b0, rdy: 1'b1, flt: 1'b0};
      ST_FAULT:                 d = '{pd: 1'b1, rst: 1'b1, rdy: 1'b0, flt: 1'b1};
      default:                  d = '{pd: 1'b1, rst: 1'b1, rdy: 1'b0, flt: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/gt_pll_rst_fsm.sv
// One PLL channel: reset synchroniser, lock/refclk synchronisers,
// power-up / lock / settle sequencing FSM and registered drives.
module gt_pll_rst_fsm
  import gt_pll_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] T_PWRUP   = 16'd400,
  parameter logic [CNT_W-1:0] T_LOCK    = 16'd50000,
  parameter logic [CNT_W-1:0] T_SETTLE  = 16'd256,
  parameter logic [3:0]       MAX_RETRY = 4'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       retry,
  input  logic       lock_async,
  input  logic       refclk_lost_async,
  output logic       pll_pd,
  output logic       pll_reset,
  output logic       pll_ready,
  output logic       pll_fault,
  output logic [2:0] state,
  output logic [7:0] relock_cnt
);

  logic [1:0]       rst_sync_q, rst_sync_d;
  logic             rst_int_n;
  logic [1:0]       lock_sync_q, lock_sync_d;
  logic [1:0]       ref_sync_q, ref_sync_d;
  logic             lock_s, ref_s;
  pll_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d, retry_inc;
  logic [7:0]       relock_q, relock_d;
  pll_drv_t         drv_q, drv_d;

  assign rst_int_n = rst_sync_q[1];
  assign lock_s    = lock_sync_q[1];
  assign ref_s     = ref_sync_q[1];

  // Shift values for the reset and input synchroniser chains
  always_comb begin
    rst_sync_d  = {rst_sync_q[0], 1'b1};
    lock_sync_d = {lock_sync_q[0], lock_async};
    ref_sync_d  = {ref_sync_q[0], refclk_lost_async};
  end

  // Reset synchroniser: asserts immediately, releases two clocks later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= rst_sync_d;
  end

  // Next state, counters and registered drives; EN=0 outranks refclk loss,
  // which outranks lock/timeout events
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    relock_d  = relock_q;
    retry_inc = retry_q + 4'd1;
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_PWRUP;
        ST_PWRUP: begin
          if (ref_s)                               state_d = ST_REFWAIT;
          else if (cnt_q == T_PWRUP - 16'd1)       state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (ref_s)       state_d = ST_REFWAIT;
          else if (lock_s) state_d = ST_SETTLE;
          else if (cnt_q == T_LOCK - 16'd1) begin
            retry_d = retry_inc;
            state_d = (retry_inc < MAX_RETRY) ? ST_PWRUP : ST_FAULT;
          end
        end
        ST_SETTLE: begin
          if (ref_s)                               state_d = ST_REFWAIT;
          else if (!lock_s)                        state_d = ST_WAIT_LOCK;
          else if (cnt_q == T_SETTLE - 16'd1)      state_d = ST_READY;
        end
        ST_READY: begin
          if (ref_s) begin
            state_d = ST_REFWAIT;
          end else if (!lock_s) begin
            relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
            state_d  = ST_PWRUP;
          end
        end
        ST_REFWAIT: begin
          if (!ref_s) state_d = ST_PWRUP;
        end
        ST_FAULT: begin
          if (retry) begin
            state_d = ST_PWRUP;
            retry_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (state_d == ST_IDLE || state_d == ST_READY) retry_d = '0;
    if (state_d != state_q) cnt_d = '0;
    else if (cnt_q == '1)   cnt_d = cnt_q;
    else                    cnt_d = cnt_q + 1'b1;
    // Drives are registered from the next state so they align with state_q
    drv_d = state_drive(state_d);
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      lock_sync_q <= '0;
      ref_sync_q  <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      relock_q    <= '0;
      drv_q       <= state_drive(ST_IDLE);
    end else begin
      lock_sync_q <= lock_sync_d;
      ref_sync_q  <= ref_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      drv_q       <= drv_d;
    end
  end

  assign pll_pd     = drv_q.pd;
  assign pll_reset  = drv_q.rst;
  assign pll_ready  = drv_q.rdy;
  assign pll_fault  = drv_q.flt;
  assign state      = state_q;
  assign relock_cnt = relock_q;

endmodule

// File: rtl/gt_pll_reset_ctrl.sv
// Reset/power-down sequencer for the two PLLs of a GT common block.
// Both channels are fully independent instances.
module gt_pll_reset_ctrl
  import gt_pll_ctrl_pkg::*;
#(
  parameter logic [CNT_W-1:0] T_PWRUP   = 16'd400,
  parameter logic [CNT_W-1:0] T_LOCK    = 16'd50000,
  parameter logic [CNT_W-1:0] T_SETTLE  = 16'd256,
  parameter logic [3:0]       MAX_RETRY = 4'd3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN0,
  input  logic       EN1,
  input  logic       RETRY0,
  input  logic       RETRY1,
  input  logic       PLL0LOCK,
  input  logic       PLL1LOCK,
  input  logic       PLL0REFCLKLOST,
  input  logic       PLL1REFCLKLOST,
  output logic       PLL0PD,
  output logic       PLL1PD,
  output logic       PLL0RESET,
  output logic       PLL1RESET,
  output logic       PLL0READY,
  output logic       PLL1READY,
  output logic       PLL0FAULT,
  output logic       PLL1FAULT,
  output logic [2:0] STATE0,
  output logic [2:0] STATE1,
  output logic [7:0] RELOCK_CNT0,
  output logic [7:0] RELOCK_CNT1
);

  gt_pll_rst_fsm #(
    .T_PWRUP  (T_PWRUP),
    .T_LOCK   (T_LOCK),
    .T_SETTLE (T_SETTLE),
    .MAX_RETRY(MAX_RETRY)
  ) u_pll0 (
    .clk              (CLK),
    .rst_n            (RST_N),
    .en               (EN0),
    .retry            (RETRY0),
    .lock_async       (PLL0LOCK),
    .refclk_lost_async(PLL0REFCLKLOST),
    .pll_pd           (PLL0PD),
    .pll_reset        (PLL0RESET),
    .pll_ready        (PLL0READY),
    .pll_fault        (PLL0FAULT),
    .state            (STATE0),
    .relock_cnt       (RELOCK_CNT0)
  );

  gt_pll_rst_fsm #(
    .T_PWRUP  (T_PWRUP),
    .T_LOCK   (T_LOCK),
    .T_SETTLE (T_SETTLE),
    .MAX_RETRY(MAX_RETRY)
  ) u_pll1 (
    .clk              (CLK),
    .rst_n            (RST_N),
    .en               (EN1),
    .retry            (RETRY1),
    .lock_async       (PLL1LOCK),
    .refclk_lost_async(PLL1REFCLKLOST),
    .pll_pd           (PLL1PD),
    .pll_reset        (PLL1RESET),
    .pll_ready        (PLL1READY),
    .pll_fault        (PLL1FAULT),
    .state            (STATE1),
    .relock_cnt       (RELOCK_CNT1)
  );

endmodule
